decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  Instruction-decode stage, directly downstream of fetch. Consumes pc_if/instruction_if and
//  reads the 32x32 GPR file (written by write-back). Decodes control, detects load-use hazards
//  (driving stall back to fetch) and registers the ID/EX pipeline register, 1-cycle latency.
// PARAMETERS
//  NUM_REGS   32                            architectural GPRs; r0 hard-wired to zero
//  PC_RESET   Fetch::PC_RESET_VALUE         reset value of pc_id
// PORTS
//  clk              in   1   rising-edge clock
//  nrst             in   1   asynchronous active-low reset
//  pc_if            in   32  PC of instruction in IF/ID
//  instruction_if   in   32  instruction word; 0 = NOP/bubble
//  branch_taken_ex  in   1   EX resolved taken branch/jump: squash instruction in ID
//  wb_we            in   1   write-back enable
//  wb_addr          in   5   write-back destination register
//  wb_data          in   32  write-back data
//  stall            out  1   load-use hazard, to fetch (combinational)
//  pc_id            out  32  ID/EX: PC
//  rs_data_id       out  32  ID/EX: GPR[rs]
//  rt_data_id       out  32  ID/EX: GPR[rt]
//  imm_id           out  32  ID/EX: extended immediate (sign; zero for ANDI/ORI/XORI; imm<<16 for LUI)
//  rs_id/rt_id/dest_id  out 5 each  ID/EX: source/destination register numbers
//  shamt_id         out  5   ID/EX: shift amount
//  ctrl_id          out  Decode::ctrl_t  ID/EX: control bundle
//  illegal_id       out  1   ID/EX: unsupported opcode/funct seen
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-stall): all ID/EX outputs 0 except pc_id=PC_RESET;
//    all GPRs 0. stall is 0 while nrst=0.
//  - Register file: write on posedge when wb_we && wb_addr!=0. Reads combinational with
//    write-through bypass: wb_we && wb_addr==read addr && addr!=0 returns wb_data. r0 reads 0.
//  - Decode: op 0 R-type, dest=rd, funct ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/JR.
//    I-type ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI/LW (dest=rt), SW, BEQ, BNE. J, JAL (dest=31).
//    ctrl.reg_write forced 0 when dest==0. uses_rt = R-type, SW, BEQ, BNE.
//  - Hazard: hazard = ctrl_id.mem_read && dest_id!=0 &&
//    (dest_id==rs || (uses_rt && dest_id==rt)) for the instruction now in IF/ID.
//    stall = hazard && !branch_taken_ex.
//  - ID/EX update each posedge, priority:
//    1) branch_taken_ex: load bubble (ctrl=0, data/regs 0, illegal 0), pc_id<=pc_if.
//    2) stall: load bubble; pc_id<=pc_if. Fetch re-presents the instruction.
//    3) illegal: load bubble with illegal_id=1, pc_id<=pc_if.
//    4) else: load decoded fields.
//  - Bubble never triggers a hazard (mem_read=0), so stall lasts at most 1 cycle per load.
//  - Write-back to the same register as a simultaneous read: bypassed value is registered.
// STRUCTURE
//  - package Decode: opcode/funct localparams, ctrl_t packed struct {reg_write, mem_read,
//    mem_write, alu_src, branch, branch_ne, jump, jump_reg, link, alu_op[3:0]}, CTRL_NOP='0.
//  - sub-module register_file (2R1W, async reset, bypass). Decode table and hazard logic
//    are always_comb; ID/EX register is one always_ff in decode.
// TESTING
//  1 reset: nrst=0 mid-run -> all ID/EX outputs 0, pc_id=32'hffff_fffc, stall=0, r1..r31 read 0.
//  2 wb_we=1,wb_addr=5,wb_data=32'hdead_beef, same cycle ADDU r3,r5,r0 in ID -> rs_data_id=32'hdead_beef;
//    wb_addr=0 write then read r0 -> 0.
//  3 LW r2,0(r1) then ADD r4,r2,r3 -> stall=1 one cycle, bubble ctrl_id=0, then ADD with rs_id=2.
//  4 LW r2 then ADDI r4,r0,-1 (no dep) -> stall=0, imm_id=32'hffff_ffff; ORI imm 16'h8000 -> 32'h0000_8000.
//  5 load-use hazard and branch_taken_ex=1 same cycle -> stall=0, bubble loaded, pc_id=pc_if.
//  6 opcode 6'h3f -> illegal_id=1, ctrl_id=0; JAL -> dest_id=31, ctrl_id.link=1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the instruction-decode stage: opcode/funct values,
// the control bundle carried into EX, and immediate-extension helper.
package decode_pkg;

   localparam logic [31:0] PC_RESET_VALUE = 32'hffff_fffc;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   typedef enum logic [3:0] {
      ALU_NONE, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR, ALU_XOR,
      ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_t;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      logic    branch;
      logic    branch_ne;
      logic    jump;
      logic    jump_reg;
      logic    link;
      alu_op_t alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // J/JAL carry their 26-bit target index zero-extended in the immediate.
   typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_TARGET} imm_kind_t;

   function automatic logic [31:0] extend_imm(input logic [25:0] field, input imm_kind_t kind);
      logic [31:0] result;
      case (kind)
         IMM_ZERO:   result = {16'h0000, field[15:0]};
         IMM_UPPER:  result = {field[15:0], 16'h0000};
         IMM_TARGET: result = {6'b000000, field};
         default:    result = {{16{field[15]}}, field[15:0]};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/decode_register_file.sv
// 2-read/1-write GPR file with r0 fixed at zero and write-through bypass so a
// value being written back this cycle is seen by a same-cycle read.
module register_file
   import decode_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data
);

   logic [31:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rs_data = (rs_addr == 5'd0) ? 32'd0 :
                    (we && waddr == rs_addr) ? wdata : regs[rs_addr];
   assign rt_data = (rt_addr == 5'd0) ? 32'd0 :
                    (we && waddr == rt_addr) ? wdata : regs[rt_addr];

endmodule

// File: rtl/decode.sv
// Instruction-decode stage: decodes the IF/ID instruction, detects load-use
// hazards against the load now in ID/EX, and registers the ID/EX pipeline stage.
module decode
   import decode_pkg::*;
#(
   parameter int          NUM_REGS = 32,
   parameter logic [31:0] PC_RESET = PC_RESET_VALUE
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] pc_if,
   input  logic [31:0] instruction_if,
   input  logic        branch_taken_ex,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic [31:0] pc_id,
   output logic [31:0] rs_data_id,
   output logic [31:0] rt_data_id,
   output logic [31:0] imm_id,
   output logic [4:0]  rs_id,
   output logic [4:0]  rt_id,
   output logic [4:0]  dest_id,
   output logic [4:0]  shamt_id,
   output ctrl_t       ctrl_id,
   output logic        illegal_id
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [31:0] rs_data;
   logic [31:0] rt_data;

   ctrl_t       dec_ctrl;
   logic [4:0]  dec_dest;
   imm_kind_t   imm_kind;
   logic        dec_illegal;
   logic        uses_rt;
   logic        hazard;

   assign opcode = instruction_if[31:26];
   assign rs     = instruction_if[25:21];
   assign rt     = instruction_if[20:16];
   assign rd     = instruction_if[15:11];
   assign shamt  = instruction_if[10:6];
   assign funct  = instruction_if[5:0];

   register_file #(.NUM_REGS(NUM_REGS)) u_register_file (
      .clk     (clk),
      .nrst    (nrst),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .rs_addr (rs),
      .rt_addr (rt),
      .rs_data (rs_data),
      .rt_data (rt_data)
   );

   always_comb begin
      dec_ctrl    = CTRL_NOP;
      dec_dest    = 5'd0;
      imm_kind    = IMM_SIGN;
      dec_illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_dest           = rd;
            dec_ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
               FN_ADDU: dec_ctrl.alu_op = ALU_ADDU;
               FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
               FN_SUBU: dec_ctrl.alu_op = ALU_SUBU;
               FN_AND:  dec_ctrl.alu_op = ALU_AND;
               FN_OR:   dec_ctrl.alu_op = ALU_OR;
               FN_XOR:  dec_ctrl.alu_op = ALU_XOR;
               FN_NOR:  dec_ctrl.alu_op = ALU_NOR;
               FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
               FN_SLTU: dec_ctrl.alu_op = ALU_SLTU;
               FN_SLL:  dec_ctrl.alu_op = ALU_SLL;
               FN_SRL:  dec_ctrl.alu_op = ALU_SRL;
               FN_SRA:  dec_ctrl.alu_op = ALU_SRA;
               FN_JR: begin
                  dec_ctrl.reg_write = 1'b0;
                  dec_ctrl.jump      = 1'b1;
                  dec_ctrl.jump_reg  = 1'b1;
               end
               default: dec_illegal = 1'b1;
            endcase
         end
         OP_J: begin
            dec_ctrl.jump = 1'b1;
            imm_kind      = IMM_TARGET;
         end
         OP_JAL: begin
            dec_ctrl.jump      = 1'b1;
            dec_ctrl.link      = 1'b1;
            dec_ctrl.reg_write = 1'b1;
            dec_dest           = 5'd31;
            imm_kind           = IMM_TARGET;
         end
         OP_BEQ: begin
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = ALU_SUB;
         end
         OP_BNE: begin
            dec_ctrl.branch    = 1'b1;
            dec_ctrl.branch_ne = 1'b1;
            dec_ctrl.alu_op    = ALU_SUB;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            dec_dest           = rt;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            case (opcode)
               OP_ADDI:  dec_ctrl.alu_op = ALU_ADD;
               OP_ADDIU: dec_ctrl.alu_op = ALU_ADDU;
               OP_SLTI:  dec_ctrl.alu_op = ALU_SLT;
               OP_SLTIU: dec_ctrl.alu_op = ALU_SLTU;
               OP_ANDI: begin dec_ctrl.alu_op = ALU_AND; imm_kind = IMM_ZERO; end
               OP_ORI:  begin dec_ctrl.alu_op = ALU_OR;  imm_kind = IMM_ZERO; end
               OP_XORI: begin dec_ctrl.alu_op = ALU_XOR; imm_kind = IMM_ZERO; end
               default: begin dec_ctrl.alu_op = ALU_LUI; imm_kind = IMM_UPPER; end
            endcase
         end
         OP_LW: begin
            dec_dest           = rt;
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.mem_read  = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.alu_op    = ALU_ADDU;
         end
         OP_SW: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            dec_ctrl.alu_op    = ALU_ADDU;
         end
         default: dec_illegal = 1'b1;
      endcase
      // The all-zero word is the fetch bubble, not a real SLL.
      if (instruction_if == 32'd0) begin
         dec_ctrl = CTRL_NOP;
      end
      if (dec_dest == 5'd0) begin
         dec_ctrl.reg_write = 1'b0;
      end
   end

   always_comb begin
      uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                (opcode == OP_BEQ) || (opcode == OP_BNE);
      hazard  = ctrl_id.mem_read && (dest_id != 5'd0) &&
                ((dest_id == rs) || (uses_rt && (dest_id == rt)));
      stall   = nrst && hazard && !branch_taken_ex;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pc_id      <= PC_RESET;
         rs_data_id <= '0;
         rt_data_id <= '0;
         imm_id     <= '0;
         rs_id      <= '0;
         rt_id      <= '0;
         dest_id    <= '0;
         shamt_id   <= '0;
         ctrl_id    <= CTRL_NOP;
         illegal_id <= 1'b0;
      end else begin
         pc_id <= pc_if;
         if (branch_taken_ex || stall || dec_illegal) begin
            rs_data_id <= '0;
            rt_data_id <= '0;
            imm_id     <= '0;
            rs_id      <= '0;
            rt_id      <= '0;
            dest_id    <= '0;
            shamt_id   <= '0;
            ctrl_id    <= CTRL_NOP;
            illegal_id <= dec_illegal && !branch_taken_ex && !stall;
         end else begin
            rs_data_id <= rs_data;
            rt_data_id <= rt_data;
            imm_id     <= extend_imm(instruction_if[25:0], imm_kind);
            rs_id      <= rs;
            rt_id      <= rt;
            dest_id    <= dec_dest;
            shamt_id   <= shamt;
            ctrl_id    <= dec_ctrl;
            illegal_id <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: randomized instruction stream compared each
// cycle against a behavioural pipeline model, plus directed literal checks.
module tb_decode;
   import decode_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] pc_if;
   logic [31:0] instruction_if;
   logic        branch_taken_ex;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        stall;
   logic [31:0] pc_id;
   logic [31:0] rs_data_id;
   logic [31:0] rt_data_id;
   logic [31:0] imm_id;
   logic [4:0]  rs_id;
   logic [4:0]  rt_id;
   logic [4:0]  dest_id;
   logic [4:0]  shamt_id;
   ctrl_t       ctrl_id;
   logic        illegal_id;

   int n_checks = 0;
   int n_fail   = 0;
   logic seen_stall;
   logic model_stall;

   typedef struct {
      logic [31:0] pc, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, dest, shamt;
      ctrl_t       ctrl;
      logic        illegal;
   } idex_t;

   idex_t       exp_q;
   logic [31:0] gpr [32];

   logic [5:0] op_pool [20] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h05,
                                6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                                6'h02, 6'h03, 6'h3f, 6'h11};
   logic [5:0] fn_pool [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3e};

   decode dut (
      .clk             (clk),
      .nrst            (nrst),
      .pc_if           (pc_if),
      .instruction_if  (instruction_if),
      .branch_taken_ex (branch_taken_ex),
      .wb_we           (wb_we),
      .wb_addr         (wb_addr),
      .wb_data         (wb_data),
      .stall           (stall),
      .pc_id           (pc_id),
      .rs_data_id      (rs_data_id),
      .rt_data_id      (rt_data_id),
      .imm_id          (imm_id),
      .rs_id           (rs_id),
      .rt_id           (rt_id),
      .dest_id         (dest_id),
      .shamt_id        (shamt_id),
      .ctrl_id         (ctrl_id),
      .illegal_id      (illegal_id)
   );

   always #5 clk = ~clk;

   function automatic ctrl_t mk(input logic rw, mr, mw, as, br, bne, j, jr, lk, input alu_op_t op);
      ctrl_t c;
      c.reg_write = rw; c.mem_read = mr; c.mem_write = mw; c.alu_src = as;
      c.branch = br; c.branch_ne = bne; c.jump = j; c.jump_reg = jr; c.link = lk;
      c.alu_op = op;
      return c;
   endfunction

   function automatic idex_t bubble(input logic [31:0] pc);
      idex_t b;
      b.pc = pc; b.rs_data = '0; b.rt_data = '0; b.imm = '0;
      b.rs = '0; b.rt = '0; b.dest = '0; b.shamt = '0;
      b.ctrl = '0; b.illegal = 1'b0;
      return b;
   endfunction

   // Reference instruction table: control, destination and immediate per opcode.
   task automatic lookup(input logic [31:0] ins, output ctrl_t c, output logic [4:0] d,
                         output logic [31:0] im, output logic legal, output logic urt);
      logic [5:0]  op = ins[31:26];
      logic [31:0] sext = {{16{ins[15]}}, ins[15:0]};
      logic [31:0] zext = {16'h0, ins[15:0]};
      c = '0; d = 5'd0; im = sext; legal = 1'b1;
      urt = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04) || (op == 6'h05);
      case (op)
         6'h00: begin
            d = ins[15:11];
            case (ins[5:0])
               6'h20: c = mk(1,0,0,0,0,0,0,0,0, ALU_ADD);
               6'h21: c = mk(1,0,0,0,0,0,0,0,0, ALU_ADDU);
               6'h22: c = mk(1,0,0,0,0,0,0,0,0, ALU_SUB);
               6'h23: c = mk(1,0,0,0,0,0,0,0,0, ALU_SUBU);
               6'h24: c = mk(1,0,0,0,0,0,0,0,0, ALU_AND);
               6'h25: c = mk(1,0,0,0,0,0,0,0,0, ALU_OR);
               6'h26: c = mk(1,0,0,0,0,0,0,0,0, ALU_XOR);
               6'h27: c = mk(1,0,0,0,0,0,0,0,0, ALU_NOR);
               6'h2a: c = mk(1,0,0,0,0,0,0,0,0, ALU_SLT);
               6'h2b: c = mk(1,0,0,0,0,0,0,0,0, ALU_SLTU);
               6'h00: c = mk(1,0,0,0,0,0,0,0,0, ALU_SLL);
               6'h02: c = mk(1,0,0,0,0,0,0,0,0, ALU_SRL);
               6'h03: c = mk(1,0,0,0,0,0,0,0,0, ALU_SRA);
               6'h08: c = mk(0,0,0,0,0,0,1,1,0, ALU_NONE);
               default: legal = 1'b0;
            endcase
         end
         6'h02: begin c = mk(0,0,0,0,0,0,1,0,0, ALU_NONE); im = {6'h0, ins[25:0]}; end
         6'h03: begin c = mk(1,0,0,0,0,0,1,0,1, ALU_NONE); im = {6'h0, ins[25:0]}; d = 5'd31; end
         6'h04: c = mk(0,0,0,0,1,0,0,0,0, ALU_SUB);
         6'h05: c = mk(0,0,0,0,1,1,0,0,0, ALU_SUB);
         6'h08: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_ADD);  d = ins[20:16]; end
         6'h09: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_ADDU); d = ins[20:16]; end
         6'h0a: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_SLT);  d = ins[20:16]; end
         6'h0b: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_SLTU); d = ins[20:16]; end
         6'h0c: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_AND);  d = ins[20:16]; im = zext; end
         6'h0d: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_OR);   d = ins[20:16]; im = zext; end
         6'h0e: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_XOR);  d = ins[20:16]; im = zext; end
         6'h0f: begin c = mk(1,0,0,1,0,0,0,0,0, ALU_LUI);  d = ins[20:16]; im = {ins[15:0], 16'h0}; end
         6'h23: begin c = mk(1,1,0,1,0,0,0,0,0, ALU_ADDU); d = ins[20:16]; end
         6'h2b: c = mk(0,0,1,1,0,0,0,0,0, ALU_ADDU);
         default: legal = 1'b0;
      endcase
      if (ins == 32'd0) c = '0;
      if (d == 5'd0) c.reg_write = 1'b0;
   endtask

   function automatic logic [31:0] read_gpr(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_we && wb_addr == a) return wb_data;
      return gpr[a];
   endfunction

   task automatic model_reset();
      exp_q = bubble(32'hffff_fffc);
      for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_step(output logic exp_stall);
      ctrl_t c; logic [4:0] d; logic [31:0] im; logic legal, urt, haz;
      logic [4:0] s, t;
      idex_t nx;
      lookup(instruction_if, c, d, im, legal, urt);
      s = instruction_if[25:21];
      t = instruction_if[20:16];
      haz = exp_q.ctrl.mem_read && exp_q.dest != 5'd0 &&
            (exp_q.dest == s || (urt && exp_q.dest == t));
      exp_stall = haz && !branch_taken_ex;
      if (branch_taken_ex || exp_stall) begin
         nx = bubble(pc_if);
      end else if (!legal) begin
         nx = bubble(pc_if);
         nx.illegal = 1'b1;
      end else begin
         nx.pc = pc_if; nx.rs_data = read_gpr(s); nx.rt_data = read_gpr(t);
         nx.imm = im; nx.rs = s; nx.rt = t; nx.dest = d;
         nx.shamt = instruction_if[10:6]; nx.ctrl = c; nx.illegal = 1'b0;
      end
      if (wb_we && wb_addr != 5'd0) gpr[wb_addr] = wb_data;
      exp_q = nx;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic compare_idex();
      check_output("pc_id",      pc_id,              exp_q.pc);
      check_output("rs_data_id", rs_data_id,         exp_q.rs_data);
      check_output("rt_data_id", rt_data_id,         exp_q.rt_data);
      check_output("imm_id",     imm_id,             exp_q.imm);
      check_output("rs_id",      {27'd0, rs_id},     {27'd0, exp_q.rs});
      check_output("rt_id",      {27'd0, rt_id},     {27'd0, exp_q.rt});
      check_output("dest_id",    {27'd0, dest_id},   {27'd0, exp_q.dest});
      check_output("shamt_id",   {27'd0, shamt_id},  {27'd0, exp_q.shamt});
      check_output("ctrl_id",    {19'd0, ctrl_id},   {19'd0, exp_q.ctrl});
      check_output("illegal_id", {31'd0, illegal_id}, {31'd0, exp_q.illegal});
   endtask

   task automatic apply_stimulus(input logic [31:0] ins, input logic [31:0] pc, input logic bt,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
      @(negedge clk);
      instruction_if = ins; pc_if = pc; branch_taken_ex = bt;
      wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
      model_step(model_stall);
      seen_stall = stall;
      check_output("stall", {31'd0, stall}, {31'd0, model_stall});
      @(posedge clk);
      #1;
      compare_idex();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      model_reset();
      compare_idex();
      check_output("reset_pc", pc_id, 32'hffff_fffc);
      check_output("reset_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1;
      nrst = 1'b1;
      compare_idex();
   endtask

   function automatic logic [31:0] gen_instr();
      logic [5:0] op = op_pool[$urandom_range(0, 19)];
      logic [4:0] s = 5'($urandom_range(0, 7));
      logic [4:0] t = 5'($urandom_range(0, 7));
      logic [4:0] d = 5'($urandom_range(0, 7));
      logic [4:0] sh = 5'($urandom_range(0, 31));
      logic [15:0] im = 16'($urandom);
      if ($urandom_range(0, 19) == 0) return 32'd0;
      if (op == 6'h00) return {op, s, t, d, sh, fn_pool[$urandom_range(0, 14)]};
      if (op == 6'h02 || op == 6'h03) return {op, 26'($urandom)};
      return {op, s, t, im};
   endfunction

   initial begin
      logic [31:0] ins, pc;
      nrst = 1'b0; pc_if = '0; instruction_if = '0; branch_taken_ex = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_idex();
      nrst = 1'b1;

      // Write-back bypass, r0 writes ignored, stored value visible next cycle.
      apply_stimulus(32'h00a0_1821, 32'h0000_0040, 1'b0, 1'b1, 5'd5, 32'hdead_beef);
      check_output("bypass_rs", rs_data_id, 32'hdead_beef);
      apply_stimulus(32'h0000_1821, 32'h0000_0044, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
      check_output("r0_read", rs_data_id, 32'd0);
      apply_stimulus(32'h00a0_1821, 32'h0000_0048, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("r5_stored", rs_data_id, 32'hdead_beef);

      // Load-use: LW r2,0(r1) then ADD r4,r2,r3.
      apply_stimulus(32'h8c22_0000, 32'h0000_0050, 1'b0, 1'b0, 5'd0, 32'd0);
      apply_stimulus(32'h0043_2020, 32'h0000_0054, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("lu_stall", {31'd0, seen_stall}, 32'd1);
      check_output("lu_bubble", {19'd0, ctrl_id}, 32'd0);
      apply_stimulus(32'h0043_2020, 32'h0000_0054, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("lu_restall", {31'd0, seen_stall}, 32'd0);
      check_output("lu_rs", {27'd0, rs_id}, 32'd2);

      // Independent instruction after a load; immediate extension forms.
      apply_stimulus(32'h8c22_0000, 32'h0000_0060, 1'b0, 1'b0, 5'd0, 32'd0);
      apply_stimulus(32'h2004_ffff, 32'h0000_0064, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("nodep_stall", {31'd0, seen_stall}, 32'd0);
      check_output("addi_imm", imm_id, 32'hffff_ffff);
      apply_stimulus(32'h3405_8000, 32'h0000_0068, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("ori_imm", imm_id, 32'h0000_8000);

      // Hazard coinciding with a taken branch.
      apply_stimulus(32'h8c22_0000, 32'h0000_0070, 1'b0, 1'b0, 5'd0, 32'd0);
      apply_stimulus(32'h0043_2020, 32'h0000_0100, 1'b1, 1'b0, 5'd0, 32'd0);
      check_output("br_stall", {31'd0, seen_stall}, 32'd0);
      check_output("br_bubble", {19'd0, ctrl_id}, 32'd0);
      check_output("br_pc", pc_id, 32'h0000_0100);

      // Illegal opcode and JAL.
      apply_stimulus(32'hfc00_0000, 32'h0000_0104, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("illegal", {31'd0, illegal_id}, 32'd1);
      check_output("illegal_ctrl", {19'd0, ctrl_id}, 32'd0);
      apply_stimulus(32'h0c00_0010, 32'h0000_0108, 1'b0, 1'b0, 5'd0, 32'd0);
      check_output("jal_dest", {27'd0, dest_id}, 32'd31);
      check_output("jal_link", {31'd0, ctrl_id.link}, 32'd1);

      // Randomized stream; a stalled instruction is re-presented by fetch.
      pc = 32'h0000_0400;
      ins = gen_instr();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) begin
            for (int k = 1; k < 32; k++) begin
               apply_stimulus(32'd0, pc, 1'b0, 1'b1, 5'(k), 32'($urandom) | 32'h1);
            end
            do_reset();
            for (int k = 1; k < 32; k++) begin
               apply_stimulus({6'h00, 5'(k), 5'(k), 5'd0, 5'd0, 6'h25}, pc, 1'b0, 1'b0, 5'd0, 32'd0);
               check_output("post_reset_gpr", rs_data_id, 32'd0);
            end
            model_stall = 1'b0;
         end
         apply_stimulus(ins, pc, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 7)), 32'($urandom));
         if (!model_stall) begin
            pc = pc + 32'd4;
            ins = gen_instr();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
